// File: rtl/gray_updown_counter.sv
// gray_updown_counter
// Parametrised N-bit up/down Gray-code counter with count enable, parallel
// load, registered binary and Gray outputs and a terminal-count flag.
//
// Build option: define GRAY_CNT_SAT_EN to make the counter saturate at the
// ends of its range instead of wrapping modulo 2^N.
//
// Both outputs are flops loaded on the same edge from the same next-state
// value, so gray_out never glitches and bin_out is always the Gray decode of
// gray_out. tc is the only combinational output.

module gray_updown_counter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up_dn,
  input  logic         load,
  input  logic [N-1:0] load_val,
  output logic [N-1:0] gray_out,
  output logic [N-1:0] bin_out,
  output logic         tc
);

  localparam logic [N-1:0] ZERO_VAL = '0;
  localparam logic [N-1:0] MAX_VAL  = '1;
  localparam logic [N-1:0] ONE_VAL  = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0] count_val;
  logic [N-1:0] next_bin;
  logic [N-1:0] next_gray;
  logic         at_max;
  logic         at_min;

  assign at_max = (bin_out == MAX_VAL);
  assign at_min = (bin_out == ZERO_VAL);

  // Value one step away from the current count in the requested direction.
  // With saturation enabled the ends of the range hold instead of wrapping;
  // otherwise N-bit arithmetic simply drops the carry or borrow.
  always_comb begin
    count_val = bin_out;
    if (up_dn) begin
`ifdef GRAY_CNT_SAT_EN
      if (!at_max) begin
        count_val = bin_out + ONE_VAL;
      end
`else
      count_val = bin_out + ONE_VAL;
`endif
    end else begin
`ifdef GRAY_CNT_SAT_EN
      if (!at_min) begin
        count_val = bin_out - ONE_VAL;
      end
`else
      count_val = bin_out - ONE_VAL;
`endif
    end
  end

  // Pick the next binary state: load beats count, and neither means hold.
  // Reset is applied in the register block so it overrides both.
  always_comb begin
    next_bin = bin_out;
    if (load) begin
      next_bin = load_val;
    end else if (en) begin
      next_bin = count_val;
    end
  end

  // Gray encoding of the next state, so gray_out can be registered directly.
  always_comb begin
    next_gray = next_bin ^ (next_bin >> 1);
  end

  // Output registers with synchronous reset; both update on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      bin_out  <= ZERO_VAL;
      gray_out <= ZERO_VAL;
    end else begin
      bin_out  <= next_bin;
      gray_out <= next_gray;
    end
  end

  // Terminal count: the next edge will wrap (or saturate) if it counts.
  always_comb begin
    tc = en && !load && !rst && ((up_dn && at_max) || (!up_dn && at_min));
  end

endmodule

// File: tb/tb_gray_updown_counter.sv
// tb_gray_updown_counter
// Directed plus random bench for gray_updown_counter (N=4). Expected outputs
// are pushed to a scoreboard queue when stimulus is driven and popped after
// the clock edge that should produce them. Honours GRAY_CNT_SAT_EN.

module tb_gray_updown_counter;

  localparam int N = 4;
  localparam logic [N-1:0] MAX_VAL = '1;

  typedef struct packed {
    logic [N-1:0] bin;
    logic [N-1:0] gray;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         en;
  logic         up_dn;
  logic         load;
  logic [N-1:0] load_val;
  logic [N-1:0] gray_out;
  logic [N-1:0] bin_out;
  logic         tc;

  exp_t         sb[$];
  logic [N-1:0] model_b;
  logic [N-1:0] prev_gray;
  logic [N-1:0] seq_tbl [16];
  int           tests_run;
  int           tests_failed;

  gray_updown_counter #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .up_dn    (up_dn),
    .load     (load),
    .load_val (load_val),
    .gray_out (gray_out),
    .bin_out  (bin_out),
    .tc       (tc)
  );

  // Free-running clock, 10 time units per period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Safety net so the run can never hang.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Decode Gray to binary bit by bit from the MSB down.
  function automatic logic [N-1:0] gray2bin(input logic [N-1:0] g);
    logic [N-1:0] b;
    b[N-1] = g[N-1];
    for (int i = N - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of controls, check tc before the edge, then check the
  // registered outputs against the scoreboard after the edge.
  task automatic applyStimulus(input logic r, input logic e, input logic u,
                               input logic l, input logic [N-1:0] v);
    logic         exp_tc;
    logic [N-1:0] nxt;
    exp_t         item;
    int           exp_flips;
    @(negedge clk);
    rst      = r;
    en       = e;
    up_dn    = u;
    load     = l;
    load_val = v;
    #1;
    exp_tc = e & ~l & ~r & ((u & (model_b == MAX_VAL)) | (~u & (model_b == '0)));
    checkOutput("tc", 32'(tc), 32'(exp_tc));
    nxt = model_b;
    if (r) begin
      nxt = '0;
    end else if (l) begin
      nxt = v;
    end else if (e) begin
`ifdef GRAY_CNT_SAT_EN
      if (u && model_b != MAX_VAL) nxt = model_b + 1'b1;
      else if (!u && model_b != '0) nxt = model_b - 1'b1;
`else
      nxt = u ? model_b + 1'b1 : model_b - 1'b1;
`endif
    end
    sb.push_back('{bin: nxt, gray: nxt ^ (nxt >> 1)});
    prev_gray = gray_out;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checkOutput("sb_empty", 32'(1), 32'(0));
    end else begin
      item = sb.pop_front();
      checkOutput("bin_out", 32'(bin_out), 32'(item.bin));
      checkOutput("gray_out", 32'(gray_out), 32'(item.gray));
    end
    checkOutput("decode", 32'(gray2bin(gray_out)), 32'(nxt));
    if (!r && !l && e) begin
      exp_flips = (nxt != model_b) ? 1 : 0;
      checkOutput("one_bit", 32'($countones(gray_out ^ prev_gray)), 32'(exp_flips));
    end
    model_b = nxt;
  endtask

  // Directed sequence followed by a random walk.
  initial begin
    tests_run    = 0;
    tests_failed = 0;
    model_b      = '0;
    prev_gray    = '0;
    rst          = 1'b1;
    en           = 1'b0;
    up_dn        = 1'b0;
    load         = 1'b0;
    load_val     = '0;
    seq_tbl = '{4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

    // Reset held for two edges with en high.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'h0);
    checkOutput("reset_gray", 32'(gray_out), 32'h0);
    checkOutput("reset_bin", 32'(bin_out), 32'h0);

    // Full up-count lap against the reference Gray sequence.
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
`ifndef GRAY_CNT_SAT_EN
      checkOutput("seq_gray", 32'(gray_out), 32'(seq_tbl[i]));
`else
      if (i < 15) checkOutput("seq_gray", 32'(gray_out), 32'(seq_tbl[i]));
`endif
    end

    // Wrap up through 15 -> 0, then down through 0 -> 15.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'hF);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
`ifndef GRAY_CNT_SAT_EN
    checkOutput("wrap_up_bin", 32'(bin_out), 32'h0);
    checkOutput("wrap_up_gray", 32'(gray_out), 32'h0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    checkOutput("wrap_dn_bin", 32'(bin_out), 32'hF);
    checkOutput("wrap_dn_gray", 32'(gray_out), 32'h8);
`else
    checkOutput("sat_up_bin", 32'(bin_out), 32'hF);
`endif

    // Load beats a simultaneous decrement; reset beats load.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'h3);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'hA);
    checkOutput("load_bin", 32'(bin_out), 32'hA);
    checkOutput("load_gray", 32'(gray_out), 32'hF);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'h7);
    checkOutput("rst_load_bin", 32'(bin_out), 32'h0);
    checkOutput("rst_load_gray", 32'(gray_out), 32'h0);

    // Hold for three edges, then immediate direction changes.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'h5);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
      checkOutput("hold_gray", 32'(gray_out), 32'h7);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
    checkOutput("dir_dn_gray", 32'(gray_out), 32'h6);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
    checkOutput("dir_up_bin", 32'(bin_out), 32'h5);

`ifdef GRAY_CNT_SAT_EN
    // Saturation at both ends.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'hF);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'h0);
      checkOutput("sat_hi_bin", 32'(bin_out), 32'hF);
    end
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'h0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'h0);
      checkOutput("sat_lo_bin", 32'(bin_out), 32'h0);
    end
`endif

    // Random enable/direction walk with no loads.
    for (int i = 0; i < 1000; i++) begin
      applyStimulus(1'b0, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)), 1'b0, 4'h0);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/gray_updown_counter.md
Name: gray_updown_counter

Overview:
- Parametrised N-bit Gray-code counter; next-generation replacement for the fixed up-only Gray counter.
- Adds up/down direction, count enable, parallel load, and both binary and Gray outputs.
- Adds a terminal-count flag.
- Used as a pointer/sequence source where single-bit-change outputs are required, e.g. async FIFO pointers and encoder emulation.

Parameters:
- N, 4, counter width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset; sampled on rising edge of clk.
- en  input  1  count enable; the counter steps one position per clk while high.
- up_dn  input  1  direction: 1 = count up, 0 = count down.
- load  input  1  synchronous parallel load strobe.
- load_val  input  N  binary value to load.
- gray_out  output  N  registered Gray-code count.
- bin_out  output  N  registered binary count; always equals the Gray decode of gray_out.
- tc  output  1  terminal count / wrap indicator (combinational from registered state and inputs).

Behaviour:
- State: internal binary register b[N-1:0]. Both outputs are flops updated on the same edge, so there is no combinational path to gray_out or bin_out.
- Gray encoding: gray_out = b ^ (b >> 1), computed from the next value of b and registered.
- Reset: when rst=1 at a clk edge, on that edge b=0, bin_out=0, gray_out=0. tc then follows the tc rule from the reset state (with rst still high it is 0).
- Priority per edge: rst > load > en. At most one action occurs per edge.
- Load: load=1 (and rst=0) sets bin_out=load_val and gray_out=load_val^(load_val>>1) on that edge. en and up_dn are ignored in that cycle.
- Count: en=1, load=0, rst=0:
  - up_dn=1: b <= b+1, mod 2^N.
  - up_dn=0: b <= b-1, mod 2^N.
- Hold: en=0, load=0, rst=0 holds all outputs unchanged.
- Latency: one cycle from sampled control to updated outputs.
- Single-bit property: every count step (including the wrap 2^N-1 <-> 0) changes exactly one bit of gray_out. Load and reset are exempt.
- tc = en & ~load & ~rst & ((up_dn & b==2^N-1) | (~up_dn & b==0)).
  - tc high means the next edge wraps (or saturates, see Optional Feature).
- Direction change: takes effect on the very next enabled edge, with no dead cycle. Example: up to 5 then down gives 5 -> 4.
- Reset mid-operation: abandons any pending load or count. No other state exists.
- Width rules: arithmetic is N bits, discarding the carry/borrow. load_val wider values are not possible by construction.

Optional Feature:
- Macro: GRAY_CNT_SAT_EN.
- Defined:
  - counting up at b=2^N-1 holds at 2^N-1;
  - counting down at b=0 holds at 0;
  - tc still asserts under the same rule and indicates saturation;
  - load and reset are unaffected.
- Undefined: the counter wraps modulo 2^N as described in Behaviour.

Test Plan:
- Reset: rst=1 for 2 edges with en=1, then rst=0, en=1, up_dn=1 -> gray_out 0x0 during reset. Then 16 edges give the sequence 0x1,0x3,0x2,0x6,0x7,0x5,0x4,0xC,0xD,0xF,0xE,0xA,0xB,0x9,0x8,0x0 (N=4). bin_out steps 1..15,0.
- Wrap and tc: load load_val=15, then en=1, up_dn=1 -> tc=1 while bin_out=15. Next edge bin_out=0, gray_out=0x0; only bit 3 of gray_out toggled. Down from 0 -> tc=1, next value bin_out=15, gray_out=0x8.
- Load priority: bin_out=3, load=1, load_val=10, en=1, up_dn=0 -> next edge bin_out=10, gray_out=0xF, with no decrement applied. Assert load together with rst -> outputs 0.
- Hold/direction: from bin_out=5 (gray 0x7), en=0 for 3 edges -> unchanged. Then en=1, up_dn=0 -> 4 (gray 0x6). Then up_dn=1 -> 5.
- Single-bit check: random en/up_dn over 1000 cycles with no load -> a monitor confirms popcount(gray_out ^ prev) <= 1 each edge, and bin_out == Gray decode of gray_out.
- GRAY_CNT_SAT_EN build: at bin_out=15, up, en=1 for 3 edges -> stays 15, tc=1 throughout. At 0 down -> stays 0.
